// File: rtl/key_pkg.sv
// Shared types and timing constants for the pushbutton conditioner.
package key_pkg;

    // Per-key auto-repeat state.
    typedef enum logic [1:0] {
        REL      = 2'd0,
        HOLD_DLY = 2'd1,
        HOLD_RPT = 2'd2
    } rpt_state_e;

    // Board timing at 50 MHz: 20 ms debounce, 0.5 s first repeat, 0.1 s repeat.
    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 25000000;
    localparam int DEF_REPEAT_PERIOD   = 5000000;

    // Shortened timing so simulation exercises every path in a few cycles.
    localparam int SIM_DEBOUNCE_CYCLES = 4;
    localparam int SIM_REPEAT_DELAY    = 10;
    localparam int SIM_REPEAT_PERIOD   = 3;

    // Largest of three values, used to size the shared timer width.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One pushbutton: 2-flop synchroniser, debounce counter, press/release
// pulse generator and auto-repeat step FSM. All outputs are registered.
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    input  logic repeat_en,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_step
);

    // Both timers share one width, large enough for the longest interval.
    localparam int TW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [TW-1:0] DB_LAST  = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);
    localparam logic [TW-1:0] TMR_MAX  = '1;

    // The synchroniser carries the raw active-low level, so its reset value
    // of 1 means "released".
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [TW-1:0]   db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            step_q, step_d;
    rpt_state_e      state_q, state_d;
    logic [TW-1:0]   rpt_tmr_q, rpt_tmr_d;

    logic            pressed;
    logic            rise;
    logic            fall;

    // Synchronise, debounce and derive the accepted-edge events.
    always_comb begin
        sync1_d   = key_n;
        sync2_d   = sync1_q;
        pressed   = ~sync2_q;
        level_d   = level_q;
        db_cnt_d  = db_cnt_q;
        rise      = 1'b0;
        fall      = 1'b0;
        if (pressed == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q >= DB_LAST) begin
            // Stable long enough: accept the new level.
            level_d  = pressed;
            db_cnt_d = '0;
            rise     = pressed;
            fall     = ~pressed;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
        press_d   = rise;
        release_d = fall;
    end

    // Auto-repeat FSM: step on press, then after the delay, then every period.
    always_comb begin
        state_d   = state_q;
        rpt_tmr_d = rpt_tmr_q;
        step_d    = 1'b0;
        case (state_q)
            REL: begin
                rpt_tmr_d = '0;
                if (rise) begin
                    state_d = HOLD_DLY;
                    step_d  = 1'b1;
                end
            end
            HOLD_DLY: begin
                if (fall) begin
                    // Release wins over a coincident repeat tick.
                    state_d   = REL;
                    rpt_tmr_d = '0;
                end else if (!repeat_en) begin
                    rpt_tmr_d = '0;
                end else if (rpt_tmr_q >= DLY_LAST) begin
                    state_d   = HOLD_RPT;
                    rpt_tmr_d = '0;
                    step_d    = 1'b1;
                end else if (rpt_tmr_q != TMR_MAX) begin
                    rpt_tmr_d = rpt_tmr_q + 1'b1;
                end
            end
            HOLD_RPT: begin
                if (fall) begin
                    state_d   = REL;
                    rpt_tmr_d = '0;
                end else if (!repeat_en) begin
                    state_d   = HOLD_DLY;
                    rpt_tmr_d = '0;
                end else if (rpt_tmr_q >= PER_LAST) begin
                    rpt_tmr_d = '0;
                    step_d    = 1'b1;
                end else if (rpt_tmr_q != TMR_MAX) begin
                    rpt_tmr_d = rpt_tmr_q + 1'b1;
                end
            end
            default: begin
                state_d   = REL;
                rpt_tmr_d = '0;
            end
        endcase
    end

    // State and output registers; reset drops all outputs at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            step_q    <= 1'b0;
            state_q   <= REL;
            rpt_tmr_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            step_q    <= step_d;
            state_q   <= state_d;
            rpt_tmr_q <= rpt_tmr_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_step    = step_q;

endmodule

// File: rtl/key_step_conditioner.sv
// Conditions the raw active-low DE2 KEY buttons into debounced levels,
// press/release pulses and an auto-repeating step pulse per key.
module key_step_conditioner
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_step
);

    // One fully independent channel per key.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk         (CLOCK_50),
            .rst_n       (reset_n),
            .key_n       (KEY[i]),
            .repeat_en   (repeat_en[i]),
            .key_level   (key_level[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_step    (key_step[i])
        );
    end

endmodule

// File: doc/key_step_conditioner.md
Name: key_step_conditioner

Overview:
Conditions the raw active-low DE2 pushbuttons (KEY) before they reach the 3-bit T flip-flop counter.
- Synchronises and debounces each key.
- Emits single-cycle press/release pulses and a step pulse train with optional auto-repeat.
- Runs on CLOCK_50. Its key_step/key_level outputs replace direct KEY wiring to the counter's clk/load inputs.

Parameters:
NUM_KEYS, 4, number of independent key channels
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz)
REPEAT_DELAY, 25000000, cycles from accepted press to first auto-repeat step
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat steps

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
KEY  in  NUM_KEYS  raw pushbuttons, active-low (0 = pressed), asynchronous
repeat_en  in  NUM_KEYS  per-key auto-repeat enable, synchronous to CLOCK_50
key_level  out  NUM_KEYS  debounced level, 1 = pressed
key_press  out  NUM_KEYS  1-cycle pulse on accepted press
key_release  out  NUM_KEYS  1-cycle pulse on accepted release
key_step  out  NUM_KEYS  1-cycle pulse on press plus each auto-repeat tick

Behaviour:
Interface:
- One clock, CLOCK_50. Reset reset_n is asynchronous and active-low.
- All outputs are registered; every channel is fully independent.

Reset:
- key_level, key_press, key_release and key_step are all 0.
- Synchroniser flops reset to 1 (released).
- Debounce and repeat timers reset to 0; FSM resets to REL.

Synchroniser:
- Two flops per key; s2 is the inverted, synchronised KEY (1 = pressed).

Debounce:
- Counter clears whenever s2 == key_level.
- Counter increments on each cycle s2 != key_level.
- Counter at DEBOUNCE_CYCLES-1 with s2 still differing: key_level toggles on the next edge and the counter clears.
- Latency from a clean KEY edge to key_level change: DEBOUNCE_CYCLES+2 clock edges.
- Any bounce shorter than DEBOUNCE_CYCLES restarts the count and produces no output change.

Pulses:
- key_press is high exactly in the first cycle key_level reads 1.
- key_release is high exactly in the first cycle key_level reads 0.
- Each pulse is never wider than 1 cycle.

Repeat FSM, per key (states REL, HOLD_DLY, HOLD_RPT):
- REL: on press, go to HOLD_DLY, clear timer, assert key_step together with key_press.
- HOLD_DLY: timer counts while repeat_en=1. When timer reaches REPEAT_DELAY-1, assert key_step, go to HOLD_RPT, clear timer.
- HOLD_RPT: when timer reaches REPEAT_PERIOD-1, assert key_step and clear timer.
- repeat_en=0 in HOLD_DLY or HOLD_RPT: go to HOLD_DLY with timer held at 0; no repeat steps.
- Release in any state: go to REL, clear timer, no key_step. If release coincides with a repeat tick, release wins (no step).
- Resulting step times with repeat_en=1 and press in cycle P: P, P+REPEAT_DELAY, then every REPEAT_PERIOD.

Widths and timers:
- Timer widths come from $clog2 of the largest parameter; no wrap is possible.
- Timers saturate; there is no modulo arithmetic.

Reset mid-operation:
- Asserting reset_n at any point drops all outputs immediately and returns the FSM to REL.
- After reset deassertion with KEY still held, a fresh press is accepted after DEBOUNCE_CYCLES+2 edges.

Decomposition:
Shared package key_pkg:
- Repeat FSM state enum (REL, HOLD_DLY, HOLD_RPT).
- Default timing constants for 50 MHz.
- Reduced simulation constants (DEBOUNCE 4, DELAY 10, PERIOD 3).

Sub-module key_channel:
- One key's synchroniser, debounce counter, pulse generator and repeat FSM.
- The top generates NUM_KEYS instances of it.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Reset, KEY=4'b1111 -> all outputs 0; after release of reset, still 0 for 50 cycles.
2. Bounce: KEY[0] toggles every 2 cycles for 12 cycles, then holds 0 at cycle T -> no pulses during bounce; key_level[0] rises, and key_press[0]/key_step[0] pulse once, at T+6.
3. Clean hold of KEY[1] for 30 cycles, repeat_en[1]=1, press accepted at P -> key_step[1] at P, P+10, P+13, P+16, P+19, ...; stops on release; key_release[1] pulses once, 6 cycles after KEY[1] returns to 1.
4. Held KEY[2] with a 3-cycle high glitch -> key_level[2] stays 1, no release or press pulses; repeat_en[2]=0 -> only the initial step.
5. KEY[0] and KEY[3] pressed in the same cycle -> simultaneous identical pulses on bits 0 and 3; bits 1 and 2 stay 0.
6. reset_n asserted in HOLD_RPT with KEY[0] held -> outputs 0 asynchronously; after deassertion, key_press[0] pulses 6 cycles later, then repeats restart at +10.
